// File: rtl/cpht_update_ctrl_if.sv
// rtl/cpht_update_ctrl_if.sv - lookup and update handshake bundle for the chooser table
interface cpht_update_ctrl_if #(
    parameter int IDX_W = 6
);
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_ready;
    logic             lk_rsp_valid;
    logic             lk_sel;
    logic             up_valid;
    logic [IDX_W-1:0] up_idx;
    logic             up_p1_res;
    logic             up_p2_res;
    logic             up_ready;

    modport master (
        output lk_valid, lk_idx, up_valid, up_idx, up_p1_res, up_p2_res,
        input  lk_ready, lk_rsp_valid, lk_sel, up_ready
    );

    modport slave (
        input  lk_valid, lk_idx, up_valid, up_idx, up_p1_res, up_p2_res,
        output lk_ready, lk_rsp_valid, lk_sel, up_ready
    );
endinterface

// File: rtl/cpht_update_ctrl.sv
// rtl/cpht_update_ctrl.sv - tournament chooser table with update FIFO and init sweep
module cpht_update_ctrl #(
    parameter  int IDX_W  = 6,
    parameter  int QDEPTH = 4,
    localparam int CW     = $clog2(QDEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    cpht_update_ctrl_if.slave      bus,
    output logic                   init_busy,
    output logic [CW-1:0]          q_count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int EW = IDX_W + 2;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] sweep_ptr;

    logic [1:0]       tbl [2**IDX_W];
    logic [EW-1:0]    fifo_mem [QDEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    logic             push;
    logic             pop;
    logic [EW-1:0]    head;
    logic [IDX_W-1:0] head_idx;
    logic [1:0]       cur_cnt;
    logic [1:0]       new_cnt;
    logic             lk_rsp_valid_q;
    logic             lk_sel_q;

    assign head     = fifo_mem[rd_ptr];
    assign head_idx = head[EW-1:2];
    assign cur_cnt  = tbl[head_idx];

    // State register: reset always restarts the sweep
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_INIT;
        else         state <= state_nxt;
    end

    // Next state: leave INIT after the last entry has been cleared
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && sweep_ptr == {IDX_W{1'b1}}) state_nxt = ST_RUN;
    end

    // Outputs and strobes decoded from state and occupancy
    always_comb begin
        init_busy    = (state == ST_INIT);
        bus.lk_ready = (state == ST_RUN);
        bus.up_ready = (state == ST_RUN) && (q_count < CW'(QDEPTH));
        push         = bus.up_valid && bus.up_ready;
        pop          = (state == ST_RUN) && (q_count != '0) && resetn;
    end

    // Saturating chooser update for the FIFO head
    always_comb begin
        new_cnt = cur_cnt;
        case (head[1:0])
            2'b10:   new_cnt = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'b01;
            2'b01:   new_cnt = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'b01;
            default: new_cnt = cur_cnt;
        endcase
    end

    // Sweep pointer advances once per INIT cycle
    always_ff @(posedge clk) begin
        if (!resetn)                sweep_ptr <= '0;
        else if (state == ST_INIT)  sweep_ptr <= sweep_ptr + 1'b1;
    end

    // Single write port: sweep clears in INIT, head RMW in RUN
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state == ST_INIT) tbl[sweep_ptr] <= 2'b00;
            else if (pop)         tbl[head_idx]  <= new_cnt;
        end
    end

    // FIFO storage: write at tail on accepted update
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.up_idx, bus.up_p1_res, bus.up_p2_res};
    end

    // FIFO pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Lookup response, bypassing this cycle's RMW result when indices match
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lk_rsp_valid_q <= 1'b0;
            lk_sel_q       <= 1'b0;
        end else if (bus.lk_valid && bus.lk_ready) begin
            lk_rsp_valid_q <= 1'b1;
            lk_sel_q       <= (pop && head_idx == bus.lk_idx) ? new_cnt[1] : tbl[bus.lk_idx][1];
        end else begin
            lk_rsp_valid_q <= 1'b0;
        end
    end

    assign bus.lk_rsp_valid = lk_rsp_valid_q;
    assign bus.lk_sel       = lk_sel_q;
endmodule

// File: doc/cpht_update_ctrl.md
Name: cpht_update_ctrl

Overview:
- Owns the chooser table for the tournament branch predictor: 2^IDX_W two-bit chooser counters that select between predictor P1 and predictor P2.
- Serves one lookup per cycle from fetch and buffers resolved-branch updates from commit in a small FIFO.
- Drains at most one update per cycle through a single read-modify-write port.
- Initialises the whole table after reset with a sequenced sweep.

Parameters:
- IDX_W, 6, table index width; the table holds 2^IDX_W entries.
- QDEPTH, 4, depth of the update FIFO; must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- lk_valid  in  1  lookup request.
- lk_idx  in  IDX_W  lookup index.
- lk_ready  out  1  lookup accepted this cycle.
- lk_rsp_valid  out  1  lookup response valid; asserted one cycle after an accepted lookup.
- lk_sel  out  1  chooser result: 0 selects P1, 1 selects P2.
- up_valid  in  1  update request.
- up_idx  in  IDX_W  update index.
- up_p1_res  in  1  P1 predicted correctly.
- up_p2_res  in  1  P2 predicted correctly.
- up_ready  out  1  FIFO can accept an update.
- init_busy  out  1  initialisation sweep in progress.
- q_count  out  $clog2(QDEPTH)+1  current FIFO occupancy.

Behaviour:
- Counter encoding: 00 strongly P1, 01 weakly P1, 10 weakly P2, 11 strongly P2. lk_sel is counter bit 1.
- Update rule, applied to the entry at the FIFO head:
  - p1=1, p2=0: decrement, saturating at 00.
  - p1=0, p2=1: increment, saturating at 11.
  - p1=p2 (both correct or both wrong): hold.
- FSM states: INIT and RUN.
- Reset (resetn=0 at a clk edge, in any state, mid-sweep or mid-drain):
  - state enters INIT with sweep pointer 0.
  - FIFO is emptied; q_count=0.
  - lk_rsp_valid=0, lk_sel=0.
  - init_busy=1, up_ready=0, lk_ready=0.
- INIT:
  - Each cycle writes 00 to the entry at the sweep pointer, then increments the pointer.
  - After the write of entry 2^IDX_W-1 the FSM moves to RUN on the next edge. The sweep lasts exactly 2^IDX_W cycles after reset deasserts.
  - init_busy=1 throughout INIT. lk_ready=0 and up_ready=0. Requests presented during INIT are ignored, not queued.
- RUN:
  - init_busy=0 and lk_ready=1 every cycle.
  - up_ready=1 when q_count<QDEPTH.
  - RUN has no exit except reset.
- Lookup:
  - Accepted when lk_valid and lk_ready.
  - Next cycle: lk_rsp_valid=1, and lk_sel reflects the table contents after this cycle's write (write-first bypass).
  - If no lookup is accepted, lk_rsp_valid=0 next cycle and lk_sel holds its last value.
  - Updates still waiting in the FIFO are not forwarded to lookups; the FIFO is not searched.
- Enqueue: when up_valid and up_ready, push {up_idx, up_p1_res, up_p2_res} at the tail.
- Drain: in RUN with q_count>0, each cycle pops the head, reads its entry, applies the update rule, and writes the result back in the same cycle.
- Simultaneous push and pop: occupancy is unchanged. When the FIFO is full, up_ready=0 even though a pop occurs that cycle; there is no same-cycle refill of a full queue.
- Back-to-back updates to the same index: each applies to the result of the previous one, because the RMW completes within one cycle.
- FIFO pointers are log2(QDEPTH) bits and wrap modulo QDEPTH. q_count is an explicit counter with range 0..QDEPTH.
- All outputs are driven from registers except up_ready and lk_ready, which are combinational from state and q_count.

Test Plan:
- Reset sweep: IDX_W=6; hold resetn=0 for 2 cycles, release. Required: init_busy=1 for exactly 64 cycles. A lookup of every index 0..63 afterwards returns lk_sel=0, with lk_rsp_valid one cycle after each request.
- Saturation: issue five updates to idx 5 with (p1=0, p2=1). Required: counter goes 01, 10, 11, 11, 11; a lookup of idx 5 gives lk_sel=1. Then issue three updates (p1=1, p2=0) and one (1,1). Required: counter ends at 00 and the lookup gives lk_sel=0.
- Backpressure: QDEPTH=4; push 4 updates on consecutive cycles while the drain runs. Required: q_count stays ≤4. Separately, push 6 updates in a burst with up_valid held. Required: up_ready drops only when q_count=4, and all 6 updates are eventually applied in order.
- Same-cycle bypass: entry 9=01; the head update for idx 9 is (0,1) and lk_idx=9 in the same cycle. Required: next cycle lk_rsp_valid=1 and lk_sel=1 (new value 10).
- Hold cases: updates (0,0) and (1,1) to idx 3 holding 10. Required: the entry stays 10 and q_count returns to 0.
- Reset mid-drain: queue 3 updates, then assert resetn=0 for 1 cycle. Required: q_count=0 and init_busy=1. After 64 cycles every entry is 00 and no queued update is applied.
